b1_smpl_queue: RTL and testbench

B1_SMPL_QUEUE -- requirements
Module: b1_smpl_queue

---
 rtl/b1_smpl_queue.sv | 100 ++++++++++
 tb/tb_b1_smpl_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/b1_smpl_queue.sv
// Circular stereo sample queue feeding the FIR; once full, each accepted
// write triggers a DEPTH-cycle oldest-to-newest readout.
module b1_smpl_queue #(
    parameter int DEPTH = 1021,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt_smpl,
    input  logic [15:0] lft_smpl_in,
    input  logic [15:0] rht_smpl_in,
    output logic [15:0] lft_smpl_out,
    output logic [15:0] rht_smpl_out,
    output logic        sequencing,
    output logic        dropped
);

    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] READ = 2'd2;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [31:0]   mem [DEPTH];
    logic [1:0]    state;
    logic [AW-1:0] new_ptr;
    logic [AW-1:0] old_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] cnt;
    logic [AW-1:0] rd_cnt;
    logic          wr_en;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign wr_en = wrt_smpl && (state != READ);

    // Storage is deliberately not reset; a full refill precedes any readout.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[new_ptr] <= {lft_smpl_in, rht_smpl_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FILL;
            new_ptr      <= '0;
            old_ptr      <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            rd_cnt       <= '0;
            sequencing   <= 1'b0;
            dropped      <= 1'b0;
            lft_smpl_out <= '0;
            rht_smpl_out <= '0;
        end else begin
            dropped <= wrt_smpl && (state == READ);
            unique case (state)
                FILL: begin
                    if (wrt_smpl) begin
                        new_ptr <= nxt(new_ptr);
                        cnt     <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state      <= READ;
                            sequencing <= 1'b1;
                            rd_ptr     <= old_ptr;
                            rd_cnt     <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (wrt_smpl) begin
                        new_ptr    <= nxt(new_ptr);
                        old_ptr    <= nxt(old_ptr);
                        rd_ptr     <= nxt(old_ptr);
                        rd_cnt     <= '0;
                        state      <= READ;
                        sequencing <= 1'b1;
                    end
                end
                READ: begin
                    {lft_smpl_out, rht_smpl_out} <= mem[rd_ptr];
                    rd_ptr <= nxt(rd_ptr);
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_cnt == LAST) begin
                        state      <= WAIT;
                        sequencing <= 1'b0;
                    end
                end
                default: begin
                    state      <= FILL;
                    sequencing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_b1_smpl_queue.sv
// Randomized bench for b1_smpl_queue: a small (DEPTH=5) and a full-size
// instance share stimulus and are checked against a queue-based model.
module tb_b1_smpl_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrt = 1'b0;
    logic [15:0] lft = '0;
    logic [15:0] rht = '0;

    logic [15:0] s_l, s_r, b_l, b_r;
    logic        s_seq, s_drop, b_seq, b_drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    b1_smpl_queue #(.DEPTH(5), .AW(3)) u_small (
        .clk          (clk),
        .rst_n        (rst_n),
        .wrt_smpl     (wrt),
        .lft_smpl_in  (lft),
        .rht_smpl_in  (rht),
        .lft_smpl_out (s_l),
        .rht_smpl_out (s_r),
        .sequencing   (s_seq),
        .dropped      (s_drop)
    );

    b1_smpl_queue u_big (
        .clk          (clk),
        .rst_n        (rst_n),
        .wrt_smpl     (wrt),
        .lft_smpl_in  (lft),
        .rht_smpl_in  (rht),
        .lft_smpl_out (b_l),
        .rht_smpl_out (b_r),
        .sequencing   (b_seq),
        .dropped      (b_drop)
    );

    function automatic int dep(input int i);
        return (i == 0) ? 5 : 1021;
    endfunction

    // Model: history of the last DEPTH accepted pairs; a full history
    // snapshots into a readout list that drains one pair per cycle.
    logic [31:0] hist [2][$];
    logic [31:0] rdq  [2][$];
    int          rd_left [2] = '{0, 0};
    logic [31:0] m_out   [2] = '{32'd0, 32'd0};
    logic        m_seq   [2] = '{1'b0, 1'b0};
    logic        m_drop  [2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                hist[i].delete();
                rdq[i].delete();
                rd_left[i] = 0;
                m_out[i]   = '0;
                m_seq[i]   = 1'b0;
                m_drop[i]  = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_drop[i] = wrt && (rd_left[i] > 0);
                if (rd_left[i] > 0) begin
                    m_out[i] = rdq[i].pop_front();
                    rd_left[i]--;
                end else if (wrt) begin
                    if (hist[i].size() == dep(i))
                        void'(hist[i].pop_front());
                    hist[i].push_back({lft, rht});
                    if (hist[i].size() == dep(i)) begin
                        rdq[i]     = hist[i];
                        rd_left[i] = dep(i);
                    end
                end
                m_seq[i] = (rd_left[i] > 0);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("s_out", {s_l, s_r}, m_out[0]);
        chk("s_seq", 32'(s_seq), 32'(m_seq[0]));
        chk("s_drop", 32'(s_drop), 32'(m_drop[0]));
        chk("b_out", {b_l, b_r}, m_out[1]);
        chk("b_seq", 32'(b_seq), 32'(m_seq[1]));
        chk("b_drop", 32'(b_drop), 32'(m_drop[1]));
    endtask

    task automatic tick(input logic w, input logic [15:0] l,
                        input logic [15:0] r);
        @(negedge clk);
        check_all();
        wrt = w;
        lft = l;
        rht = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0);
    endtask

    int  seq_cyc;
    int  drp_cyc;
    bit  found;

    initial begin
        repeat (3) @(posedge clk);
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;

        // fill, steady-state wrap and overrun on the small instance
        for (int k = 1; k <= 5; k++) begin
            tick(1'b1, 16'(k), ~16'(k));
            tick(1'b0, '0, '0);
        end
        idle(8);
        tick(1'b1, 16'd6, 16'd60);
        tick(1'b0, '0, '0);
        tick(1'b1, 16'd99, 16'd99);
        idle(8);
        tick(1'b1, 16'd7, 16'd70);
        idle(8);
        tick(1'b1, 16'h8000, 16'h7fff);
        idle(8);

        // reset during the third readout cycle
        tick(1'b1, 16'd42, 16'd43);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1'b0, '0, '0);
            if (rd_left[0] == 3) found = 1'b1;
        end
        chk("rd_reach", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_seq", 32'(s_seq), 32'd0);
        chk("rst_out", {s_l, s_r}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) tick(1'b1, 16'(k + 200), 16'(k));
        idle(8);

        // full-depth ramp on the large instance
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        seq_cyc = 0;
        drp_cyc = 0;
        for (int k = 0; k < 1021; k++) begin
            tick(1'b1, 16'(k), 16'(k) ^ 16'h5a5a);
            if (b_seq) seq_cyc++;
            if (b_drop) drp_cyc++;
        end
        for (int k = 0; k < 1030; k++) begin
            tick(1'b0, '0, '0);
            if (b_seq) seq_cyc++;
            if (b_drop) drp_cyc++;
        end
        chk("big_seq_len", 32'(seq_cyc), 32'd1021);
        chk("big_drop", 32'(drp_cyc), 32'd0);

        // random traffic at varying write densities
        for (int k = 0; k < 3000; k++) begin
            int lim;
            lim = (k < 1500) ? 1 : 6;
            tick($urandom_range(0, lim) == 0, 16'($urandom), 16'($urandom));
        end
        idle(1030);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
